// File: rtl/rob_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rob_wb_arbiter
//
// Purpose:
//   Shares the single ROB status write-back port among REQ execution units.
//   Each unit owns a one-entry holding slot. A round-robin arbiter picks one
//   valid slot per cycle and loads it into a registered write-back stage that
//   drives the ROB status write inputs. All control flags are active-low
//   (Enable_ = 0, Disable_ = 1).
//
// Optional feature (macro ROB_WB_EXP_PRIO_EN):
//   When defined, slots carrying an exception, mispredict or jump miss are
//   arbitrated first (round-robin within that class). When undefined, plain
//   round-robin is used.
//
// Ports:
//   clk            clock
//   reset_         asynchronous reset, active-low
//   flush_         pipeline flush from commit, active-low
//   req_           per-unit write-back request, active-low
//   req_rob_id     per-unit ROB id
//   req_exp_       per-unit exception flag, active-low
//   req_exp_code   per-unit exception code
//   req_pred_miss_ per-unit branch mispredict, active-low
//   req_jump_miss_ per-unit jump target miss, active-low
//   req_busy       slot cannot accept this cycle, active-high
//   wb_e_          ROB status write enable, active-low
//   wb_rob_id      ROB id written
//   wb_exp_        exception flag written
//   wb_exp_code    exception code written
//   wb_pred_miss_  mispredict flag written
//   wb_jump_miss_  jump miss flag written
// ---------------------------------------------------------------------------

`ifndef RobDepth
`define RobDepth 16
`endif

package rob_wb_pkg;
    typedef logic [3:0] ExpCode_t;
    localparam ExpCode_t EXP_I_MISS_ALIGN = 4'd0;
    localparam ExpCode_t EXP_I_FAULT      = 4'd1;
    localparam ExpCode_t EXP_ILL_INST     = 4'd2;
    localparam ExpCode_t EXP_BREAK        = 4'd3;
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;
endpackage

module rob_wb_arbiter
    import rob_wb_pkg::*;
#(
    parameter int REQ       = 4,
    parameter int ROB_DEPTH = `RobDepth,
    localparam int ROB      = $clog2(ROB_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     flush_,
    input  logic [REQ-1:0]           req_,
    input  logic [REQ-1:0][ROB-1:0]  req_rob_id,
    input  logic [REQ-1:0]           req_exp_,
    input  ExpCode_t [REQ-1:0]       req_exp_code,
    input  logic [REQ-1:0]           req_pred_miss_,
    input  logic [REQ-1:0]           req_jump_miss_,
    output logic [REQ-1:0]           req_busy,
    output logic                     wb_e_,
    output logic [ROB-1:0]           wb_rob_id,
    output logic                     wb_exp_,
    output ExpCode_t                 wb_exp_code,
    output logic                     wb_pred_miss_,
    output logic                     wb_jump_miss_
);

    localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;

    // Holding slots
    logic [REQ-1:0]          r_vld;
    logic [REQ-1:0][ROB-1:0] r_rob_id;
    logic [REQ-1:0]          r_exp_;
    ExpCode_t [REQ-1:0]      r_exp_code;
    logic [REQ-1:0]          r_pred_miss_;
    logic [REQ-1:0]          r_jump_miss_;
    logic [PW-1:0]           r_rr_ptr;

    // Write-back stage
    logic                    r_wb_e_;
    logic [ROB-1:0]          r_wb_rob_id;
    logic                    r_wb_exp_;
    ExpCode_t                r_wb_exp_code;
    logic                    r_wb_pred_miss_;
    logic                    r_wb_jump_miss_;

    logic                    w_flush;
    logic                    w_gnt_vld;
    logic                    w_take;
    logic [PW-1:0]           w_gnt_idx;
    logic [REQ-1:0]          w_gnt;
    logic [REQ-1:0]          w_accept;

    assign w_flush = (flush_ == Enable_);

`ifdef ROB_WB_EXP_PRIO_EN
    logic [REQ-1:0] w_hi;
    always_comb begin
        for (int i = 0; i < REQ; i++) begin
            w_hi[i] = (r_exp_[i] == Enable_) || (r_pred_miss_[i] == Enable_) ||
                      (r_jump_miss_[i] == Enable_);
        end
    end
`endif

    // Round-robin search starting at r_rr_ptr; first hit wins.
    always_comb begin
        logic [PW-1:0] idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        idx       = '0;
`ifdef ROB_WB_EXP_PRIO_EN
        for (int k = 0; k < REQ; k++) begin
            idx = PW'((int'(r_rr_ptr) + k) % REQ);
            if (!w_gnt_vld && r_vld[idx] && w_hi[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = idx;
            end
        end
`endif
        for (int k = 0; k < REQ; k++) begin
            idx = PW'((int'(r_rr_ptr) + k) % REQ);
            if (!w_gnt_vld && r_vld[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = idx;
            end
        end
    end

    // A flush cancels the grant so the slot is not written back.
    assign w_take = w_gnt_vld && !w_flush;

    always_comb begin
        w_gnt = '0;
        if (w_take) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    // Granted slot is free for refill on the same edge.
    assign req_busy = w_flush ? '0 : (r_vld & ~w_gnt);

    always_comb begin
        for (int i = 0; i < REQ; i++) begin
            w_accept[i] = (req_[i] == Enable_) && !req_busy[i] && !w_flush;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_vld           <= '0;
            r_rob_id        <= '0;
            r_exp_          <= {REQ{Disable_}};
            r_exp_code      <= '0;
            r_pred_miss_    <= {REQ{Disable_}};
            r_jump_miss_    <= {REQ{Disable_}};
            r_rr_ptr        <= '0;
            r_wb_e_         <= Disable_;
            r_wb_rob_id     <= '0;
            r_wb_exp_       <= Disable_;
            r_wb_exp_code   <= EXP_I_MISS_ALIGN;
            r_wb_pred_miss_ <= Disable_;
            r_wb_jump_miss_ <= Disable_;
        end else begin
            for (int i = 0; i < REQ; i++) begin
                if (w_flush) begin
                    r_vld[i] <= 1'b0;
                end else if (w_accept[i]) begin
                    r_vld[i]        <= 1'b1;
                    r_rob_id[i]     <= req_rob_id[i];
                    r_exp_[i]       <= req_exp_[i];
                    r_exp_code[i]   <= req_exp_code[i];
                    r_pred_miss_[i] <= req_pred_miss_[i];
                    r_jump_miss_[i] <= req_jump_miss_[i];
                end else if (w_gnt[i]) begin
                    r_vld[i] <= 1'b0;
                end
            end

            if (w_take) begin
                r_rr_ptr        <= PW'((int'(w_gnt_idx) + 1) % REQ);
                r_wb_e_         <= Enable_;
                r_wb_rob_id     <= r_rob_id[w_gnt_idx];
                r_wb_exp_       <= r_exp_[w_gnt_idx];
                r_wb_exp_code   <= r_exp_code[w_gnt_idx];
                r_wb_pred_miss_ <= r_pred_miss_[w_gnt_idx];
                r_wb_jump_miss_ <= r_jump_miss_[w_gnt_idx];
            end else begin
                r_wb_e_ <= Disable_;
            end
        end
    end

    assign wb_e_         = r_wb_e_;
    assign wb_rob_id     = r_wb_rob_id;
    assign wb_exp_       = r_wb_exp_;
    assign wb_exp_code   = r_wb_exp_code;
    assign wb_pred_miss_ = r_wb_pred_miss_;
    assign wb_jump_miss_ = r_wb_jump_miss_;

endmodule
